// File: rtl/ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// ps2_rx_fifo
//
// Receives 11-bit PS/2 keyboard frames and queues the 8-bit scan codes in a
// small FIFO for the scan-code-to-ASCII stage.
//
// Frame on the wire (one bit per falling ps2_clk edge, LSB first):
//   bit 0      start, must be 0
//   bits 8..1  scan code, bit 1 is data[0]
//   bit 9      odd parity over bits 8..1
//   bit 10     stop, must be 1
//
// Parameters
//   DEPTH_LOG2  FIFO depth is 2**DEPTH_LOG2 scan codes (must be >= 1)
//   TIMEOUT     idle clk cycles after which a partial frame is abandoned
//
// Ports
//   clk         system clock, all state updates on its rising edge
//   clrn        asynchronous active-low reset
//   ps2_clk     raw PS/2 clock, asynchronous to clk
//   ps2_data    raw PS/2 data, asynchronous to clk
//   nextdata_n  active-low pop request from the consumer
//   data        scan code at the FIFO head (combinational read)
//   ready       registered, high while the FIFO holds at least one code
//   overflow    registered, sticky: a valid frame was lost to a full FIFO
//   frame_err   registered, one-cycle pulse when a frame is rejected
// ---------------------------------------------------------------------------
module ps2_rx_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int TIMEOUT    = 10000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int PTR_W  = DEPTH_LOG2 + 1;
    localparam int IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
    localparam logic [3:0]        LAST_BIT   = 4'd10;

    // Odd parity check: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        odd_parity_ok = ((^bits) == 1'b1);
    endfunction

    // -----------------------------------------------------------------------
    // Input synchronisation and falling-edge detection
    // -----------------------------------------------------------------------
    logic [2:0] ps2_clk_sync_r;
    logic [1:0] ps2_data_sync_r;
    logic       fall_s;
    logic       bit_s;

    // Synchronizer chains for the two asynchronous PS/2 lines.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ps2_clk_sync_r  <= 3'b000;
            ps2_data_sync_r <= 2'b00;
        end else begin
            ps2_clk_sync_r  <= {ps2_clk_sync_r[1:0], ps2_clk};
            ps2_data_sync_r <= {ps2_data_sync_r[0], ps2_data};
        end
    end

    // The two oldest clock samples reading 1 then 0 mark a falling edge;
    // clearing the chain to zero on reset means no false edge after release.
    assign fall_s = (ps2_clk_sync_r[2] == 1'b1) && (ps2_clk_sync_r[1] == 1'b0);
    assign bit_s  = ps2_data_sync_r[1];

    // -----------------------------------------------------------------------
    // Frame assembly
    // -----------------------------------------------------------------------
    logic [3:0]        bit_cnt_r;
    logic [3:0]        bit_cnt_next_s;
    logic [9:0]        shift_r;          // bits 0..9 of the frame once complete
    logic [9:0]        shift_next_s;
    logic [IDLE_W-1:0] idle_cnt_r;
    logic [IDLE_W-1:0] idle_next_s;
    logic              frame_valid_s;
    logic              frame_ok_next_s;
    logic              frame_bad_next_s;
    logic              frame_ok_r;       // valid frame waiting to be written
    logic [7:0]        frame_byte_r;
    logic              frame_err_r;

    // The stop bit is never stored: it is the bit sampled on the 11th edge.
    assign frame_valid_s = (shift_r[0] == 1'b0) && (bit_s == 1'b1)
                           && odd_parity_ok(shift_r[9:1]);

    // Bit counting, shift register, idle timeout and frame verdict.
    always_comb begin
        bit_cnt_next_s   = bit_cnt_r;
        shift_next_s     = shift_r;
        idle_next_s      = idle_cnt_r;
        frame_ok_next_s  = 1'b0;
        frame_bad_next_s = 1'b0;
        if (fall_s) begin
            idle_next_s = '0;
            if (bit_cnt_r == LAST_BIT) begin
                bit_cnt_next_s = 4'd0;
                if (frame_valid_s) begin
                    frame_ok_next_s = 1'b1;
                end else begin
                    frame_bad_next_s = 1'b1;
                end
            end else begin
                // Right shift: after ten edges the first bit sits at index 0.
                shift_next_s   = {bit_s, shift_r[9:1]};
                bit_cnt_next_s = bit_cnt_r + 4'd1;
            end
        end else if (bit_cnt_r == 4'd0) begin
            idle_next_s = '0;
        end else if (idle_cnt_r >= IDLE_LIMIT) begin
            // Keyboard went quiet mid-frame: silently abandon it.
            bit_cnt_next_s = 4'd0;
            idle_next_s    = '0;
        end else begin
            idle_next_s = idle_cnt_r + IDLE_ONE;
        end
    end

    // Receiver state registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bit_cnt_r    <= 4'd0;
            shift_r      <= 10'd0;
            idle_cnt_r   <= '0;
            frame_ok_r   <= 1'b0;
            frame_byte_r <= 8'd0;
            frame_err_r  <= 1'b0;
        end else begin
            bit_cnt_r    <= bit_cnt_next_s;
            shift_r      <= shift_next_s;
            idle_cnt_r   <= idle_next_s;
            frame_ok_r   <= frame_ok_next_s;
            frame_byte_r <= shift_r[8:1];
            frame_err_r  <= frame_bad_next_s;
        end
    end

    // -----------------------------------------------------------------------
    // Scan-code FIFO
    // -----------------------------------------------------------------------
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wptr_r;
    logic [PTR_W-1:0] rptr_r;
    logic [PTR_W-1:0] wptr_next_s;
    logic [PTR_W-1:0] rptr_next_s;
    logic             ready_r;
    logic             overflow_r;
    logic             full_s;
    logic             wr_en_s;
    logic             pop_s;

    // Extra pointer MSB distinguishes full from empty, so every entry is usable.
    assign full_s  = (wptr_r[PTR_W-1] != rptr_r[PTR_W-1])
                     && (wptr_r[PTR_W-2:0] == rptr_r[PTR_W-2:0]);
    // Full is judged before any same-cycle pop, so such a write is dropped.
    assign wr_en_s = frame_ok_r && !full_s;
    assign pop_s   = !nextdata_n && ready_r;

    // Pointer advance for the write and pop of this cycle.
    always_comb begin
        wptr_next_s = wptr_r;
        rptr_next_s = rptr_r;
        if (wr_en_s) begin
            wptr_next_s = wptr_r + PTR_ONE;
        end else begin
            wptr_next_s = wptr_r;
        end
        if (pop_s) begin
            rptr_next_s = rptr_r + PTR_ONE;
        end else begin
            rptr_next_s = rptr_r;
        end
    end

    // Pointers and status flags.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wptr_r     <= '0;
            rptr_r     <= '0;
            ready_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            wptr_r     <= wptr_next_s;
            rptr_r     <= rptr_next_s;
            ready_r    <= (wptr_next_s != rptr_next_s);
            overflow_r <= overflow_r || (frame_ok_r && full_s);
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wptr_r[PTR_W-2:0]] <= frame_byte_r;
        end
    end

    assign data      = mem[rptr_r[PTR_W-2:0]];
    assign ready     = ready_r;
    assign overflow  = overflow_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_ps2_rx_fifo
//
// Scoreboard bench: the stimulus side drives PS/2 frames and pops, and keeps
// the expected FIFO contents as a queue derived from the frame rules; a
// monitor on the falling clk edge compares every popped scan code and counts
// frame_err pulses.
// ---------------------------------------------------------------------------
module tb_ps2_rx_fifo;

    localparam int DEPTH_LOG2 = 3;
    localparam int DEPTH      = 8;
    localparam int TIMEOUT    = 100;

    logic       clk = 1'b0;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    logic       exp_overflow = 1'b0;
    int         err_exp  = 0;
    int         err_seen = 0;
    logic       prev_err = 1'b0;

    ps2_rx_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every cycle the consumer asks for data, compare against the queue head.
    always @(negedge clk) begin
        if (clrn) begin
            if (!nextdata_n) begin
                check("pop_ready", 32'(ready), 32'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    check("pop_data", 32'(data), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
            if (frame_err) begin
                err_seen++;
                check("err_pulse_width", 32'(prev_err), 32'(0));
            end
            prev_err = frame_err;
        end else begin
            prev_err = 1'b0;
        end
    end

    // One PS/2 bit: data set up while ps2_clk is high, then a low pulse.
    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (3) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (5) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Build an 11-bit frame; kind 0 good, 1 bad parity, 2 bad start, 3 bad stop.
    function automatic logic [10:0] make_frame(input logic [7:0] b, input int kind);
        logic [10:0] f;
        f[0]   = (kind == 2);
        f[8:1] = b;
        f[9]   = (($countones(b) % 2) == 0) ^ (kind == 1);
        f[10]  = (kind != 3);
        return f;
    endfunction

    task automatic settle_checks();
        repeat (4) @(posedge clk);
        #1;
        check("overflow", 32'(overflow), 32'(exp_overflow));
        check("frame_err_count", 32'(err_seen), 32'(err_exp));
        check("ready_idle", 32'(ready), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("head_data", 32'(data), 32'(exp_q[0]));
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int kind);
        logic [10:0] f;
        logic        valid;
        f = make_frame(b, kind);
        for (int i = 0; i < 11; i++) begin
            ps2_bit(f[i]);
        end
        ps2_data = 1'b1;
        valid = (f[0] == 1'b0) && (f[10] == 1'b1) && (($countones(f[9:1]) % 2) == 1);
        if (valid) begin
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back(b);
            end else begin
                exp_overflow = 1'b1;
            end
        end else begin
            err_exp++;
        end
        settle_checks();
    endtask

    task automatic send_partial(input int nbits, input logic [10:0] f);
        for (int i = 0; i < nbits; i++) begin
            ps2_bit(f[i]);
        end
        ps2_data = 1'b1;
    endtask

    task automatic pop(input int n);
        nextdata_n = 1'b0;
        repeat (n) @(posedge clk);
        #1 nextdata_n = 1'b1;
        check("ready_after_pop", 32'(ready), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("data_after_pop", 32'(data), 32'(exp_q[0]));
        end
    endtask

    task automatic pulse_reset();
        clrn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'(0));
        check("rst_overflow", 32'(overflow), 32'(0));
        check("rst_frame_err", 32'(frame_err), 32'(0));
        clrn = 1'b1;
        exp_q.delete();
        exp_overflow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int kind;
        int nb;
        clrn       = 1'b0;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        nextdata_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        pulse_reset();

        // Single frame then pop.
        send_frame(8'h1C, 0);
        pop(1);

        // Two frames back to back, popped in order.
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);
        pop(1);
        pop(1);

        // Wrong parity.
        send_frame(8'h5A, 1);

        // Partial frame abandoned by the idle timeout, then a good frame.
        send_partial(5, make_frame(8'hA5, 0));
        repeat (TIMEOUT + 20) @(posedge clk);
        #1;
        check("timeout_no_err", 32'(err_seen), 32'(err_exp));
        send_frame(8'h5A, 0);
        pop(1);

        // Nine frames with no pops: the ninth overflows.
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 0);
        end
        pop(8);
        pop(1);

        // Reset mid-frame clears overflow and the partial frame.
        send_partial(4, make_frame(8'h16, 0));
        pulse_reset();
        send_frame(8'h16, 0);
        pop(1);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                nb = $urandom_range(1, 10);
                send_partial(nb, 11'($urandom));
                repeat (TIMEOUT + 20) @(posedge clk);
                #1;
            end else begin
                kind = (r <= 2) ? $urandom_range(1, 3) : 0;
                send_frame(8'($urandom), kind);
            end
            nb = $urandom_range(0, 3);
            if (nb > 0) begin
                pop(nb);
            end
        end
        pop(DEPTH + 1);
        check("final_err_count", 32'(err_seen), 32'(err_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
